pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core; sits beside the ID-stage forwarding unit.
//  Detects load-use hazards that forwarding cannot cover and inserts a one-cycle bubble.
//  Flushes IF/ID on a taken branch or jump, and drains the pipeline after a HALT decode.
//  Gates the pipeline for debug single-step. Drives the PC, IF/ID and ID/EX write controls.
// PARAMETERS
//  NB_ADDR      5   register address width
//  DRAIN_CYCLES 4   cycles spent draining EX/MEM/WB after HALT before o_halted (>=1)
//  NB_CNT       3   drain counter width, >= clog2(DRAIN_CYCLES)
//  NB_STALL     16  stall performance counter width
// PORTS
//  i_clk          in  1        system clock, rising edge
//  i_rst          in  1        asynchronous reset, active-high
//  i_rs_IFID      in  NB_ADDR  rs of instruction in ID
//  i_rt_IFID      in  NB_ADDR  rt of instruction in ID
//  i_rt_IDEX      in  NB_ADDR  destination (rt) of instruction in EX
//  i_mem_rd_IDEX  in  1        instruction in EX is a load
//  i_branch_taken in  1        branch/jump resolved taken in ID
//  i_halt_IFID    in  1        HALT decoded in ID
//  i_step_en      in  1        debug single-step mode
//  i_step         in  1        advance one cycle (step mode only)
//  o_pc_wr        out 1        PC write enable
//  o_ifid_wr      out 1        IF/ID register write enable
//  o_ifid_flush   out 1        clear IF/ID to NOP
//  o_idex_bubble  out 1        load NOP controls into ID/EX
//  o_pipe_en      out 1        global enable for ID/EX, EX/MEM, MEM/WB
//  o_halted       out 1        pipeline empty after HALT (registered)
//  o_state        out 2        current FSM state (registered)
//  o_stall_cnt    out NB_STALL count of load-use stall cycles (registered)
// BEHAVIOUR
//  - States: RUN=2'b00, DRAIN=2'b01, HALTED=2'b10. Reset: state RUN, drain count 0, o_stall_cnt 0, o_halted 0.
//  - While i_rst=1: o_pc_wr, o_ifid_wr, o_pipe_en, o_ifid_flush and o_idex_bubble are all 0.
//  - Control outputs are combinational from state and inputs (same-cycle effect).
//  - adv = !i_step_en || i_step. When adv=0: o_pipe_en=o_pc_wr=o_ifid_wr=0, flush=bubble=0.
//    No state, counter or stall-count change. Otherwise o_pipe_en=1.
//  - lu = i_mem_rd_IDEX && i_rt_IDEX!=0 && (i_rt_IDEX==i_rs_IFID || i_rt_IDEX==i_rt_IFID).
//  - RUN, adv=1, priority lu > halt > branch:
//      lu:      pc_wr=0, ifid_wr=0, bubble=1, flush=0; stall_cnt+1 (saturating at all-ones)
//      halt:    pc_wr=0, ifid_wr=1, flush=1, bubble=0; next DRAIN, cnt=DRAIN_CYCLES-1
//               (the HALT itself enters ID/EX as a NOP)
//      branch:  pc_wr=1, ifid_wr=1, flush=1
//      none:    pc_wr=1, ifid_wr=1, flush=0, bubble=0
//  - Branch suppressed by lu is re-evaluated the following cycle (ID holds it).
//  - DRAIN, adv=1: pc_wr=0, ifid_wr=0, bubble=1. cnt==0 -> HALTED, else cnt-1.
//    Inputs are ignored (lu/branch/halt have no effect).
//  - HALTED: pc_wr=ifid_wr=pipe_en=0, flush=bubble=0, o_halted=1; exits only via reset.
//    i_step ignored.
//  - Reset asserted mid-DRAIN or HALTED returns to RUN immediately (async).
//  - i_step_en deasserted while frozen: normal advance in the next cycle.
// STRUCTURE
//  - Package pipeline_pkg: state localparams RUN/DRAIN/HALTED and NB_ADDR.
//  - Sub-module load_use_detect (combinational lu compare, x0 exclusion); instanced once.
//  - Top: FSM + drain counter + saturating stall counter + output decode.
// TESTING
//  1 Load r5 in EX, ID uses rs=5 -> 1 cycle pc_wr=0, ifid_wr=0, bubble=1; stall_cnt 0->1.
//  2 Load to r0 in EX, ID rs=0 -> no stall, pc_wr=1.
//    Load r7 in EX, ID rt=7 -> stall.
//  3 branch_taken=1 with no hazard -> flush=1, pc_wr=1.
//    branch_taken=1 with lu=1 -> flush=0, bubble=1; next cycle flush=1.
//  4 HALT in ID, DRAIN_CYCLES=4 -> flush cycle, then 4 DRAIN cycles with bubble=1;
//    o_halted=1, o_state=2'b10 after 5 edges. Inputs are then ignored.
//  5 i_step_en=1, i_step pulsed every 3rd cycle -> pipe_en/pc_wr high only on pulse cycles.
//    Drain count advances only on pulses.
//  6 Assert i_rst during DRAIN -> o_state=RUN and o_halted=0 immediately.
//    Force 2^16 stalls -> o_stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and
// register address width.
package pipeline_pkg;

    localparam int NB_ADDR = 5;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction in ID, excluding x0 which is never a real dependency.
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int P_NB_ADDR = NB_ADDR
) (
    input  logic [P_NB_ADDR-1:0] i_rs_id,
    input  logic [P_NB_ADDR-1:0] i_rt_id,
    input  logic [P_NB_ADDR-1:0] i_rt_ex,
    input  logic                 i_mem_rd_ex,
    output logic                 o_lu
);

    logic w_dst_nonzero;
    logic w_match;

    assign w_dst_nonzero = |i_rt_ex;
    assign w_match       = (i_rt_ex == i_rs_id) || (i_rt_ex == i_rt_id);
    assign o_lu          = i_mem_rd_ex && w_dst_nonzero && w_match;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use stall, branch flush, HALT drain and debug
// single-step gating for the 5-stage core.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int P_NB_ADDR      = NB_ADDR,
    parameter int DRAIN_CYCLES   = 4,
    parameter int NB_CNT         = 3,
    parameter int NB_STALL       = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [P_NB_ADDR-1:0] i_rs_IFID,
    input  logic [P_NB_ADDR-1:0] i_rt_IFID,
    input  logic [P_NB_ADDR-1:0] i_rt_IDEX,
    input  logic                 i_mem_rd_IDEX,
    input  logic                 i_branch_taken,
    input  logic                 i_halt_IFID,
    input  logic                 i_step_en,
    input  logic                 i_step,
    output logic                 o_pc_wr,
    output logic                 o_ifid_wr,
    output logic                 o_ifid_flush,
    output logic                 o_idex_bubble,
    output logic                 o_pipe_en,
    output logic                 o_halted,
    output logic [1:0]           o_state,
    output logic [NB_STALL-1:0]  o_stall_cnt
);

    state_t              r_state;
    logic [NB_CNT-1:0]   r_cnt;
    logic [NB_STALL-1:0] r_stall_cnt;
    logic                r_halted;
    logic                w_lu;
    logic                w_adv;

    load_use_detect #(
        .P_NB_ADDR (P_NB_ADDR)
    ) u_load_use_detect (
        .i_rs_id     (i_rs_IFID),
        .i_rt_id     (i_rt_IFID),
        .i_rt_ex     (i_rt_IDEX),
        .i_mem_rd_ex (i_mem_rd_IDEX),
        .o_lu        (w_lu)
    );

    // Outside step mode every cycle advances; in step mode only pulsed ones.
    assign w_adv = !i_step_en || i_step;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_stall_cnt <= '0;
            r_halted    <= 1'b0;
        end else if (w_adv) begin
            case (r_state)
                RUN: begin
                    if (w_lu) begin
                        if (r_stall_cnt != {NB_STALL{1'b1}})
                            r_stall_cnt <= r_stall_cnt + 1'b1;
                    end else if (i_halt_IFID) begin
                        r_state <= DRAIN;
                        r_cnt   <= NB_CNT'(DRAIN_CYCLES - 1);
                    end
                end
                DRAIN: begin
                    if (r_cnt == '0) begin
                        r_state  <= HALTED;
                        r_halted <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                HALTED: ;
                default: r_state <= RUN;
            endcase
        end
    end

    always_comb begin
        o_pc_wr       = 1'b0;
        o_ifid_wr     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_en     = 1'b0;
        if (!i_rst && w_adv && r_state != HALTED) begin
            o_pipe_en = 1'b1;
            if (r_state == DRAIN) begin
                o_idex_bubble = 1'b1;
            end else if (w_lu) begin
                o_idex_bubble = 1'b1;
            end else if (i_halt_IFID) begin
                // HALT itself is flushed so it enters ID/EX as a NOP.
                o_ifid_wr    = 1'b1;
                o_ifid_flush = 1'b1;
            end else begin
                o_pc_wr      = 1'b1;
                o_ifid_wr    = 1'b1;
                o_ifid_flush = i_branch_taken;
            end
        end
    end

    assign o_state     = r_state;
    assign o_halted    = r_halted;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, directed
// multi-cycle sequences and randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_N  = 4;
    localparam int STALL_MX = 65535;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs = '0, rt = '0, rt_ex = '0;
    logic        mem_rd = 1'b0, br = 1'b0, halt = 1'b0, step_en = 1'b0, step = 1'b0;
    logic        pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en, halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt;

    int chk_cnt = 0;
    int err_cnt = 0;

    // Behavioural model: mode 0 running, 1 draining, 2 halted.
    int m_mode = 0;
    int m_left = 0;
    int m_stalls = 0;

    pipeline_hazard_ctrl #(
        .P_NB_ADDR    (5),
        .DRAIN_CYCLES (DRAIN_N),
        .NB_CNT       (3),
        .NB_STALL     (16)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_rs_IFID      (rs),
        .i_rt_IFID      (rt),
        .i_rt_IDEX      (rt_ex),
        .i_mem_rd_IDEX  (mem_rd),
        .i_branch_taken (br),
        .i_halt_IFID    (halt),
        .i_step_en      (step_en),
        .i_step         (step),
        .o_pc_wr        (pc_wr),
        .o_ifid_wr      (ifid_wr),
        .o_ifid_flush   (ifid_flush),
        .o_idex_bubble  (idex_bubble),
        .o_pipe_en      (pipe_en),
        .o_halted       (halted),
        .o_state        (state),
        .o_stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs, rt, rt_ex;
        logic        mem_rd, br, halt, step_en, step;
        logic        pc_wr, ifid_wr, flush, bubble, pipe_en;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_lu();
        return mem_rd && rt_ex != 0 && (rt_ex == rs || rt_ex == rt);
    endfunction

    function automatic logic [4:0] model_comb();
        // packs {pc_wr, ifid_wr, flush, bubble, pipe_en}
        bit adv = !step_en || step;
        if (rst || m_mode == 2 || !adv) return 5'b00000;
        if (m_mode == 1)   return 5'b00011;
        if (model_lu())    return 5'b00011;
        if (halt)          return 5'b01101;
        if (br)            return 5'b11101;
        return 5'b11001;
    endfunction

    function automatic int mode_code();
        return (m_mode == 0) ? 0 : (m_mode == 1) ? 1 : 2;
    endfunction

    task automatic model_step();
        bit adv = !step_en || step;
        if (!adv || m_mode == 2) return;
        if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end else if (model_lu()) begin
            if (m_stalls < STALL_MX) m_stalls++;
        end else if (halt) begin
            m_mode = 1;
            m_left = DRAIN_N;
        end
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_ctrl"}, {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en},
              {27'd0, model_comb()});
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_state"},  {30'd0, state}, mode_code());
        check({tag, "_halted"}, {31'd0, halted}, (m_mode == 2) ? 1 : 0);
        check({tag, "_stall"},  {16'd0, stall_cnt}, m_stalls);
    endtask

    // One clock: edge, model update, registered checks, return at negedge.
    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] a, b, c, input logic m, bb, h, se, s);
        rs = a; rt = b; rt_ex = c; mem_rd = m; br = bb; halt = h; step_en = se; step = s;
    endtask

    // Asynchronous reset raised mid-cycle; effect must be immediate.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        m_mode = 0; m_left = 0; m_stalls = 0;
        #1;
        check({tag, "_rst_ctrl"}, {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en}, 0);
        check({tag, "_rst_state"}, {30'd0, state}, 0);
        check({tag, "_rst_halted"}, {31'd0, halted}, 0);
        check({tag, "_rst_stall"}, {16'd0, stall_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //            rs  rt  rtx mem br hlt se st  pc if fl bu en stall
        vecs[0] = '{5'd5, 5'd1, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'd1};
        vecs[1] = '{5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 16'd1};
        vecs[2] = '{5'd3, 5'd7, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'd2};
        vecs[3] = '{5'd7, 5'd7, 5'd7, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 16'd2};
        vecs[4] = '{5'd1, 5'd2, 5'd3, 1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 16'd2};
        vecs[5] = '{5'd3, 5'd2, 5'd3, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 16'd3};
        vecs[6] = '{5'd3, 5'd2, 5'd0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 16'd3};
        vecs[7] = '{5'd4, 5'd2, 5'd4, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 16'd3};
        vecs[8] = '{5'd1, 5'd2, 5'd3, 1, 0, 0, 1, 1, 1, 1, 0, 0, 1, 16'd3};
        vecs[9] = '{5'd1, 5'd2, 5'd3, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 16'd3};

        // Reset held from time 0 with inputs that would otherwise enable everything.
        drive(5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0);
        @(negedge clk);
        #1;
        check("init_ctrl", {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en}, 0);
        check("init_state", {30'd0, state}, 0);
        check("init_halted", {31'd0, halted}, 0);
        check("init_stall", {16'd0, stall_cnt}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table from RUN.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].rt_ex, vecs[i].mem_rd, vecs[i].br,
                  vecs[i].halt, vecs[i].step_en, vecs[i].step);
            #1;
            check($sformatf("vec%0d_ctrl", i),
                  {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en},
                  {27'd0, vecs[i].pc_wr, vecs[i].ifid_wr, vecs[i].flush, vecs[i].bubble, vecs[i].pipe_en});
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("vec%0d_stall", i), {16'd0, stall_cnt}, {16'd0, vecs[i].stall});
            @(negedge clk);
        end

        // HALT: flush cycle, four drain cycles, then halted and deaf to inputs.
        do_reset("halt");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        #1;
        check("halt_flush", {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en}, 32'b01101);
        tick("halt_e1");
        check("halt_drain_state", {30'd0, state}, 1);
        drive(5'd3, 5'd3, 5'd3, 1, 1, 1, 0, 0);
        for (int k = 0; k < DRAIN_N; k++) begin
            #1;
            check($sformatf("drain%0d_ctrl", k),
                  {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en}, 32'b00011);
            tick($sformatf("drain%0d", k));
            check($sformatf("drain%0d_st", k), {30'd0, state}, (k == DRAIN_N - 1) ? 2 : 1);
        end
        check("halted_flag", {31'd0, halted}, 1);
        for (int k = 0; k < 4; k++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check("halted_ctrl", {27'd0, pc_wr, ifid_wr, ifid_flush, idex_bubble, pipe_en}, 0);
            tick("halted_hold");
        end

        // Single-step: drain advances only on step pulses.
        do_reset("step");
        for (int c = 0; c < 15; c++) begin
            drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 1, (c % 3 == 2));
            #1;
            check_comb("step");
            check("step_pipe_en", {31'd0, pipe_en}, (c % 3 == 2) ? 1 : 0);
            tick("step");
        end
        check("step_final_state", {30'd0, state}, 2);

        // Reset during DRAIN.
        do_reset("pre_drain");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 1, 0, 0);
        tick("rd1");
        drive(5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0);
        tick("rd2");
        check("rd_in_drain", {30'd0, state}, 1);
        do_reset("mid_drain");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ((m_mode == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0) begin
                do_reset("rnd");
            end
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 1) == 1));
            #1;
            check_comb("rnd");
            tick("rnd");
        end

        // Stall counter saturation.
        do_reset("sat");
        drive(5'd6, 5'd0, 5'd6, 1, 0, 0, 0, 0);
        for (int n = 0; n < STALL_MX - 1; n++) begin
            @(posedge clk);
            model_step();
        end
        #1;
        check("sat_fffe", {16'd0, stall_cnt}, 32'h0000FFFE);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            model_step();
        end
        #1;
        check("sat_ffff", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat_model", {16'd0, stall_cnt}, m_stalls);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
